pll_speed_sequencer: RTL and testbench

- Parametrised successor of the single-bit 60Hz-underclock PLL reconfiguration writer.
- Drives the fractional PLL reconfig management port through a configurable table of NUM_MODES speed presets.
- Adds full Avalon waitrequest handshaking, input stability filtering, request queueing, lock wait with timeout, and status outputs.
- Sits in emu beside pll_cfg; its mode_sel input comes from an OSD status field.

---
 rtl/pll_seq_pkg.sv | 35 +++
 rtl/mode_sync_filter.sv | 47 ++++
 rtl/pll_speed_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pll_speed_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types, register constants and table helper for the PLL speed sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_FRAC,
        S_WR_START,
        S_GAP,
        S_HOLDOFF,
        S_WAIT_LOCK,
        S_DONE
    } seq_state_t;

    localparam logic [5:0]  REG_MODE     = 6'd0;
    localparam logic [5:0]  REG_START    = 6'd2;
    localparam logic [31:0] MODE_WAITREQ = 32'd0;
    localparam int          TO_W         = 21;

    // Table is passed zero-extended to the 16-entry maximum so one helper serves every NUM_MODES.
    function automatic logic [31:0] table_entry(input logic [511:0] tbl, input logic [3:0] idx);
        logic [511:0] w_sh;
        w_sh = tbl >> {idx, 5'd0};
        return w_sh[31:0];
    endfunction

    function automatic seq_state_t next_after_write(input seq_state_t s);
        case (s)
            S_WR_MODE: return S_WR_FRAC;
            S_WR_FRAC: return S_WR_START;
            default:   return S_HOLDOFF;
        endcase
    endfunction

endpackage

// File: rtl/mode_sync_filter.sv
// rtl/mode_sync_filter.sv - synchronises mode_sel and only offers a candidate once it has been stable and in range
module mode_sync_filter #(
    parameter int NUM_MODES     = 2,
    parameter int MODE_W        = 1,
    parameter int RESET_MODE    = 0,
    parameter int STABLE_CYCLES = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [MODE_W-1:0] mode_sel,
    output logic [MODE_W-1:0] candidate,
    output logic              candidate_valid
);

    localparam int                CW      = $clog2(STABLE_CYCLES + 2);
    localparam logic [MODE_W-1:0] RST_VAL = MODE_W'(RESET_MODE);
    localparam logic [CW-1:0]     CNT_MAX = '1;
    localparam logic [CW-1:0]     CNT_REQ = CW'(STABLE_CYCLES);

    logic [MODE_W-1:0] r_meta;
    logic [MODE_W-1:0] r_sync;
    logic [MODE_W-1:0] r_last;
    logic [CW-1:0]     r_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_last <= RST_VAL;
            r_cnt  <= '0;
        end else begin
            r_meta <= mode_sel;
            r_sync <= r_meta;
            // A change restarts the run at one sample; an unchanged value counts up to saturation.
            if (r_sync != r_last) begin
                r_last <= r_sync;
                r_cnt  <= CW'(1);
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign candidate       = r_last;
    assign candidate_valid = (r_cnt >= CNT_REQ) && (32'(r_last) < 32'(NUM_MODES));

endmodule

// File: rtl/pll_speed_sequencer.sv
// rtl/pll_speed_sequencer.sv - writes a selected speed preset into the fractional PLL reconfig port and waits for lock
module pll_speed_sequencer #(
    parameter int                      NUM_MODES     = 2,
    parameter int                      MODE_W        = 1,
    parameter logic [NUM_MODES*32-1:0] FRAC_TABLE    = {32'd3262113561, 32'd3639383488},
    parameter int                      FRAC_ADDR     = 7,
    parameter int                      RESET_MODE    = 0,
    parameter int                      STABLE_CYCLES = 2,
    parameter int                      GAP_CYCLES    = 3,
    parameter int                      LOCK_HOLDOFF  = 16,
    parameter int                      LOCK_TIMEOUT  = 1048576
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              pll_locked,
    input  logic              mgmt_waitrequest,
    output logic              mgmt_write,
    output logic [5:0]        mgmt_address,
    output logic [31:0]       mgmt_writedata,
    output logic              busy,
    output logic [MODE_W-1:0] active_mode,
    output logic              reconfig_done,
    output logic              lock_error
);

    import pll_seq_pkg::*;

    localparam logic [511:0]      TBL_EXT  = 512'(FRAC_TABLE);
    localparam logic [5:0]        FRAC_REG = 6'(FRAC_ADDR);
    localparam logic [MODE_W-1:0] RST_VAL  = MODE_W'(RESET_MODE);

    seq_state_t        r_state;
    seq_state_t        w_next;
    seq_state_t        r_gap_ret;
    logic [MODE_W-1:0] r_target;
    logic [MODE_W-1:0] r_seq_mode;
    logic [MODE_W-1:0] r_active;
    logic              r_pending;
    logic              r_lk_meta;
    logic              r_lk_sync;
    logic [15:0]       r_ph_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_lock_err;

    logic [MODE_W-1:0] w_cand;
    logic              w_cand_valid;
    logic              w_accept;
    logic [TO_W-1:0]   w_to_next;
    logic              w_to_hit;
    logic              w_gap_last;
    logic              w_hold_last;
    logic              w_start;
    logic              w_drop;
    logic              w_timeout;
    logic              w_lock_ok;

    mode_sync_filter #(
        .NUM_MODES     (NUM_MODES),
        .MODE_W        (MODE_W),
        .RESET_MODE    (RESET_MODE),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .mode_sel        (mode_sel),
        .candidate       (w_cand),
        .candidate_valid (w_cand_valid)
    );

    assign w_accept    = mgmt_write && !mgmt_waitrequest;
    assign w_to_next   = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + TO_W'(1);
    assign w_to_hit    = 32'(w_to_next) >= 32'(LOCK_TIMEOUT);
    assign w_gap_last  = (32'(r_ph_cnt) + 32'd1) >= 32'(GAP_CYCLES);
    assign w_hold_last = (32'(r_ph_cnt) + 32'd1) >= 32'(LOCK_HOLDOFF);

    always_comb begin
        w_next         = r_state;
        mgmt_write     = 1'b0;
        mgmt_address   = REG_MODE;
        mgmt_writedata = MODE_WAITREQ;
        w_start        = 1'b0;
        w_drop         = 1'b0;
        w_timeout      = 1'b0;
        w_lock_ok      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    if (r_target != r_active) begin
                        w_start = 1'b1;
                        w_next  = S_WR_MODE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_WR_MODE, S_WR_FRAC, S_WR_START: begin
                mgmt_write = 1'b1;
                if (r_state == S_WR_FRAC) begin
                    mgmt_address   = FRAC_REG;
                    mgmt_writedata = table_entry(TBL_EXT, 4'(r_seq_mode));
                end else if (r_state == S_WR_START) begin
                    mgmt_address = REG_START;
                end
                if (!mgmt_waitrequest) begin
                    w_next = (GAP_CYCLES == 0) ? next_after_write(r_state) : S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_last) w_next = r_gap_ret;
            end
            S_HOLDOFF: begin
                if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end else if (w_hold_last) begin
                    w_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock seen in the same cycle as the timeout still counts as a good sequence.
                if (r_lk_sync) begin
                    w_lock_ok = 1'b1;
                    w_next    = S_DONE;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_gap_ret  <= S_WR_FRAC;
            r_target   <= RST_VAL;
            r_seq_mode <= RST_VAL;
            r_active   <= RST_VAL;
            r_pending  <= 1'b0;
            r_lk_meta  <= 1'b0;
            r_lk_sync  <= 1'b0;
            r_ph_cnt   <= '0;
            r_to_cnt   <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_lk_meta <= pll_locked;
            r_lk_sync <= r_lk_meta;

            if (w_next != r_state) begin
                r_ph_cnt <= '0;
            end else if (r_ph_cnt != 16'hFFFF) begin
                r_ph_cnt <= r_ph_cnt + 16'd1;
            end

            if (w_accept) r_gap_ret <= next_after_write(r_state);

            // Timeout window opens on the cycle the start write is taken.
            if (w_accept && r_state == S_WR_START) begin
                r_to_cnt <= TO_W'(1);
            end else begin
                r_to_cnt <= w_to_next;
            end

            if (w_start) r_seq_mode <= r_target;

            if (w_start || w_drop) r_pending <= 1'b0;
            if (w_cand_valid && w_cand != r_target) begin
                r_target  <= w_cand;
                r_pending <= 1'b1;
            end

            if (w_timeout || w_lock_ok) r_active <= r_seq_mode;

            if (w_timeout) begin
                r_lock_err <= 1'b1;
            end else if (w_lock_ok) begin
                r_lock_err <= 1'b0;
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign reconfig_done = (r_state == S_DONE);
    assign active_mode   = r_active;
    assign lock_error    = r_lock_err;

endmodule

// File: tb/tb_pll_speed_sequencer.sv
// tb/tb_pll_speed_sequencer.sv - directed and randomized checks of pll_speed_sequencer against a preset-table model
module tb_pll_speed_sequencer;

    localparam int MW = 2;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic [MW-1:0] mode_sel = '0;
    logic          pll_locked = 1'b1;
    logic          mgmt_waitrequest = 1'b0;
    logic          mgmt_write;
    logic [5:0]    mgmt_address;
    logic [31:0]   mgmt_writedata;
    logic          busy;
    logic [MW-1:0] active_mode;
    logic          reconfig_done;
    logic          lock_error;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int stall_left = 0;
    bit rand_wr = 1'b0;

    logic [5:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          done_act[$];
    int          done_cnt = 0;
    int          hi_cnt = 0;
    int          frac_hi = 0;
    int          frac_bad = 0;
    int          busy_seen = 0;
    int          start_cyc = -1;
    int          le_rise = -1;
    logic        le_prev = 1'b0;
    logic [31:0] exp_frac = '0;
    int          model_active = 0;

    pll_speed_sequencer #(
        .NUM_MODES     (3),
        .MODE_W        (MW),
        .FRAC_TABLE    ({32'd2863311530, 32'd3262113561, 32'd3639383488}),
        .FRAC_ADDR     (7),
        .RESET_MODE    (0),
        .STABLE_CYCLES (2),
        .GAP_CYCLES    (3),
        .LOCK_HOLDOFF  (16),
        .LOCK_TIMEOUT  (100)
    ) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .mode_sel         (mode_sel),
        .pll_locked       (pll_locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .busy             (busy),
        .active_mode      (active_mode),
        .reconfig_done    (reconfig_done),
        .lock_error       (lock_error)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [31:0] frac_of(input int m);
        case (m)
            0:       return 32'd3639383488;
            1:       return 32'd3262113561;
            default: return 32'd2863311530;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clr();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        done_act.delete();
        done_cnt  = 0;
        hi_cnt    = 0;
        frac_hi   = 0;
        frac_bad  = 0;
        busy_seen = 0;
        start_cyc = -1;
        le_rise   = -1;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int i;
        i = 0;
        while (done_cnt < n && i < budget) begin
            @(negedge clk_sys);
            i++;
        end
        chk(tag, 64'(done_cnt >= n), 1);
    endtask

    task automatic check_seq(input string tag, input int base, input int m);
        chk({tag, "_n"},  64'(wq_addr.size() >= base + 3), 1);
        chk({tag, "_a0"}, wq_addr[base],     6'd0);
        chk({tag, "_d0"}, wq_data[base],     32'd0);
        chk({tag, "_a1"}, wq_addr[base + 1], 6'd7);
        chk({tag, "_d1"}, wq_data[base + 1], frac_of(m));
        chk({tag, "_a2"}, wq_addr[base + 2], 6'd2);
        chk({tag, "_d2"}, wq_data[base + 2], 32'd0);
    endtask

    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    initial forever begin
        @(posedge clk_sys);
        #1;
        if (reset) begin
            mgmt_waitrequest = 1'b0;
        end else if (stall_left > 0 && mgmt_write && mgmt_address == 6'd7) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
        end else if (rand_wr) begin
            mgmt_waitrequest = ($urandom_range(0, 3) == 0);
        end else begin
            mgmt_waitrequest = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk_sys);
        if (!reset) begin
            if (mgmt_write) begin
                hi_cnt++;
                if (mgmt_address == 6'd7) begin
                    frac_hi++;
                    if (mgmt_writedata != exp_frac) frac_bad++;
                end
                if (!mgmt_waitrequest) begin
                    wq_addr.push_back(mgmt_address);
                    wq_data.push_back(mgmt_writedata);
                    wq_cyc.push_back(cyc);
                    if (mgmt_address == 6'd2) start_cyc = cyc;
                end
            end
            if (busy) busy_seen++;
            if (reconfig_done) begin
                done_cnt++;
                done_act.push_back(int'(active_mode));
            end
            if (lock_error && !le_prev) le_rise = cyc;
            le_prev = lock_error;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        int t7;

        reset = 1'b1;
        tick(4);
        chk("rst_write", mgmt_write, 0);
        chk("rst_addr",  mgmt_address, 0);
        chk("rst_data",  mgmt_writedata, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  reconfig_done, 0);
        chk("rst_lerr",  lock_error, 0);
        chk("rst_act",   active_mode, 0);
        reset = 1'b0;
        tick(10);
        chk("idle_busy", busy, 0);

        clr();
        exp_frac = frac_of(1);
        mode_sel = 2'd1;
        wait_done("basic_done", 1, 400);
        tick(2);
        chk("basic_nwr", wq_addr.size(), 3);
        check_seq("basic", 0, 1);
        chk("basic_gap1", 64'(wq_cyc[1] - wq_cyc[0]), 4);
        chk("basic_gap2", 64'(wq_cyc[2] - wq_cyc[1]), 4);
        chk("basic_hi", hi_cnt, 3);
        chk("basic_done_act", done_act[0], 1);
        chk("basic_act", active_mode, 1);
        chk("basic_busy", busy, 0);
        model_active = 1;

        clr();
        exp_frac   = frac_of(2);
        stall_left = 5;
        mode_sel   = 2'd2;
        wait_done("stall_done", 1, 400);
        tick(2);
        chk("stall_nwr", wq_addr.size(), 3);
        check_seq("stall", 0, 2);
        chk("stall_hold", frac_hi, 6);
        chk("stall_data", frac_bad, 0);
        chk("stall_used", stall_left, 0);
        chk("stall_act", active_mode, 2);
        model_active = 2;

        clr();
        mode_sel = 2'd0;
        tick(1);
        mode_sel = 2'd2;
        tick(30);
        chk("glitch_nwr", wq_addr.size(), 0);
        chk("glitch_busy", busy_seen, 0);
        mode_sel = 2'd3;
        tick(30);
        chk("range_nwr", wq_addr.size(), 0);
        chk("range_busy", busy_seen, 0);
        chk("range_act", active_mode, 2);
        mode_sel = 2'd2;
        tick(10);

        clr();
        mode_sel = 2'd1;
        i = 0;
        while (wq_addr.size() < 1 && i < 200) begin
            @(negedge clk_sys);
            i++;
        end
        chk("queue_first_wr", 64'(wq_addr.size() >= 1), 1);
        mode_sel = 2'd0;
        wait_done("queue_done", 2, 800);
        tick(2);
        chk("queue_nwr", wq_addr.size(), 6);
        check_seq("queue1", 0, 1);
        check_seq("queue2", 3, 0);
        chk("queue_act1", done_act[0], 1);
        chk("queue_act2", done_act[1], 0);
        chk("queue_act", active_mode, 0);
        model_active = 0;

        rand_wr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int m;
            m = int'($urandom_range(0, 2));
            clr();
            mode_sel = MW'(m);
            if (m != model_active) begin
                wait_done("rnd_done", 1, 800);
                tick(2);
                chk("rnd_nwr", wq_addr.size(), 3);
                check_seq("rnd", 0, m);
                model_active = m;
            end else begin
                tick(40);
                chk("rnd_idle_nwr", wq_addr.size(), 0);
            end
            chk("rnd_act", active_mode, model_active);
        end
        rand_wr = 1'b0;
        tick(4);

        t7 = (model_active == 2) ? 1 : 2;
        pll_locked = 1'b0;
        clr();
        mode_sel = MW'(t7);
        wait_done("to_done", 1, 800);
        tick(2);
        chk("to_nwr", wq_addr.size(), 3);
        chk("to_err", lock_error, 1);
        chk("to_delay", 64'(le_rise - start_cyc), 100);
        chk("to_act", active_mode, t7);

        pll_locked = 1'b1;
        clr();
        mode_sel = 2'd0;
        wait_done("relock_done", 1, 800);
        tick(2);
        chk("relock_err", lock_error, 0);
        chk("relock_act", active_mode, 0);

        clr();
        stall_left = 1000;
        mode_sel   = 2'd1;
        i = 0;
        while (!(mgmt_write && mgmt_address == 6'd7) && i < 400) begin
            @(negedge clk_sys);
            i++;
        end
        chk("rstw_stalled", 64'(mgmt_write && mgmt_address == 6'd7), 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rstw_write", mgmt_write, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_act", active_mode, 0);
        stall_left = 0;
        tick(1);
        reset = 1'b0;
        clr();
        wait_done("rstw_done", 1, 800);
        tick(2);
        chk("rstw_nwr", wq_addr.size(), 3);
        check_seq("rstw", 0, 1);
        chk("rstw_final_act", active_mode, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
